axi4_ram_responder: RTL and testbench

//  AXI4 slave (responder) backed by an internal word-addressed RAM; the far end
//  of the MIG adapter's AXI4 master port. Used as a synthesizable stand-in for the
//  MIG/DDR in simulation and in FPGA builds without external memory. Serves one

---
 rtl/axi4_ram_responder_if.sv | 65 ++++++
 rtl/axi4_ram_responder.sv | 160 ++++++++++++++++
 tb/tb_axi4_ram_responder.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_ram_responder_if.sv
// AXI4 channel bundle between a master and the RAM responder (32-bit data, INCR bursts).
// Valid/ready rule on every channel: a beat transfers on a rising edge where valid && ready; once valid rises, payload holds until that edge.
interface axi4_ram_responder_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_ram_responder.sv
// AXI4 slave backed by a word-addressed RAM; one INCR burst in flight at a time,
// byte-strobed writes, SLVERR for unsupported burst/size or wlast misplacement.
module axi4_ram_responder #(
    parameter int ADDR_BITS = 10,
    parameter bit READ_PRIO = 1'b0,
    parameter int ID_W      = 4
) (
    input  logic                clk,
    input  logic                reset,
    axi4_ram_responder_if.slave axi,
    output logic [1:0]          dbg_state
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {IDLE = 2'd0, WDATA = 2'd1, WRESP = 2'd2, RDATA = 2'd3} state_t;

    state_t               state_q, state_d;
    logic [31:0]          mem [DEPTH];
    logic                 idle_rdy_q, wready_q, bvalid_q, rvalid_q, rlast_q, err_q;
    logic [ID_W-1:0]      id_q, bid_q, rid_q;
    logic [1:0]           bresp_q, rresp_q;
    logic [31:0]          rdata_q;
    logic [ADDR_BITS-1:0] ptr_q, ptr_nxt;
    logic [7:0]           len_q, cnt_q;
    logic                 aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic                 aw_err, ar_err, w_last_beat, w_err_nxt;
    logic                 unused_ok;

    // The losing request of a simultaneous AW/AR sees ready low and stays pending.
    assign axi.awready = idle_rdy_q && !(READ_PRIO && axi.arvalid);
    assign axi.arready = idle_rdy_q && !(!READ_PRIO && axi.awvalid);
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = rlast_q;
    assign dbg_state   = state_q;

    assign aw_hs       = axi.awvalid && axi.awready;
    assign ar_hs       = axi.arvalid && axi.arready;
    assign w_hs        = axi.wvalid && wready_q;
    assign b_hs        = bvalid_q && axi.bready;
    assign r_hs        = rvalid_q && axi.rready;
    assign aw_err      = (axi.awburst != 2'b01) || (axi.awsize != 3'd2);
    assign ar_err      = (axi.arburst != 2'b01) || (axi.arsize != 3'd2);
    assign w_last_beat = (cnt_q == len_q);
    assign w_err_nxt   = err_q || (axi.wlast != w_last_beat);
    assign ptr_nxt     = ptr_q + ADDR_BITS'(1);
    assign unused_ok   = ^{axi.awaddr[31:ADDR_BITS+2], axi.awaddr[1:0],
                           axi.araddr[31:ADDR_BITS+2], axi.araddr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (aw_hs) state_d = WDATA;
                     else if (ar_hs) state_d = RDATA;
            WDATA:   if (w_hs && w_last_beat) state_d = WRESP;
            WRESP:   if (b_hs) state_d = IDLE;
            RDATA:   if (r_hs && rlast_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_rdy_q <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            err_q      <= 1'b0;
            id_q       <= '0;
            bid_q      <= '0;
            rid_q      <= '0;
            bresp_q    <= 2'b00;
            rresp_q    <= 2'b00;
            rdata_q    <= 32'h0;
            ptr_q      <= '0;
            len_q      <= 8'd0;
            cnt_q      <= 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Ready comes up one cycle after entering IDLE, giving the 1-cycle gap.
                    idle_rdy_q <= 1'b1;
                    if (aw_hs) begin
                        idle_rdy_q <= 1'b0;
                        wready_q   <= 1'b1;
                        id_q       <= axi.awid;
                        ptr_q      <= axi.awaddr[ADDR_BITS+1:2];
                        len_q      <= axi.awlen;
                        cnt_q      <= 8'd0;
                        err_q      <= aw_err;
                    end else if (ar_hs) begin
                        idle_rdy_q <= 1'b0;
                        id_q       <= axi.arid;
                        ptr_q      <= axi.araddr[ADDR_BITS+1:2];
                        len_q      <= axi.arlen;
                        cnt_q      <= 8'd0;
                        err_q      <= ar_err;
                        rvalid_q   <= 1'b1;
                        rid_q      <= axi.arid;
                        rresp_q    <= ar_err ? 2'b10 : 2'b00;
                        rlast_q    <= (axi.arlen == 8'd0);
                        rdata_q    <= ar_err ? 32'h0 : mem[axi.araddr[ADDR_BITS+1:2]];
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        ptr_q <= ptr_nxt;
                        cnt_q <= cnt_q + 8'd1;
                        err_q <= w_err_nxt;
                        if (w_last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            bresp_q  <= w_err_nxt ? 2'b10 : 2'b00;
                        end
                    end
                end
                WRESP: begin
                    if (b_hs) bvalid_q <= 1'b0;
                end
                RDATA: begin
                    if (r_hs) begin
                        if (rlast_q) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                        end else begin
                            // Prefetch the next beat so rready held high streams without bubbles.
                            ptr_q   <= ptr_nxt;
                            cnt_q   <= cnt_q + 8'd1;
                            rlast_q <= ((cnt_q + 8'd1) == len_q);
                            rdata_q <= err_q ? 32'h0 : mem[ptr_nxt];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM keeps its contents across reset; the beat that flags a wlast error is still written.
    always_ff @(posedge clk) begin
        if (w_hs && !err_q) begin
            for (int k = 0; k < 4; k++) begin
                if (axi.wstrb[k]) mem[ptr_q][8*k +: 8] <= axi.wdata[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi4_ram_responder.sv
// Randomized bench for axi4_ram_responder: a memory model predicts every B/R response,
// a negedge monitor checks responses and hold-while-stalled behaviour.
module tb_axi4_ram_responder;
    localparam int DEPTH = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;

    axi4_ram_responder_if #(.ID_W(4)) axi ();

    axi4_ram_responder #(.ADDR_BITS(10), .READ_PRIO(1'b0), .ID_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .axi       (axi),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [39:0] exp_q[$];          // {is_read, id, resp, last, data}
    logic [31:0] model_mem [DEPTH];
    logic [31:0] wdata_a [256];
    logic [3:0]  wstrb_a [256];
    logic [3:0]  pat = 4'b1001;     // rready per cycle, LSB first: 1,0,0,1
    bit          rr_random = 1'b0, br_random = 1'b0, rr_manual = 1'b0;
    int          r_beats = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response-side readies, re-driven just after every rising edge.
    always @(posedge clk) begin
        #1;
        if (!rr_manual) axi.rready = rr_random ? 1'($urandom_range(0, 1)) : 1'b1;
        axi.bready = br_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every handshake and checks stalled payloads hold.
    logic [38:0] r_prev;
    logic [5:0]  b_prev;
    logic        r_stall = 1'b0, b_stall = 1'b0;
    always @(negedge clk) begin
        logic [39:0] e;
        if (reset) begin
            r_stall = 1'b0;
            b_stall = 1'b0;
        end else begin
            if (r_stall) check("r_hold", 64'({axi.rvalid, axi.rid, axi.rresp, axi.rlast, axi.rdata}), 64'({1'b1, r_prev}));
            if (b_stall) check("b_hold", 64'({axi.bvalid, axi.bid, axi.bresp}), 64'({1'b1, b_prev}));
            if (axi.rvalid && axi.rready) begin
                r_beats++;
                if (exp_q.size() == 0) check("r_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("r_beat", 64'({1'b1, axi.rid, axi.rresp, axi.rlast, axi.rdata}), 64'(e));
                end
            end
            if (axi.bvalid && axi.bready) begin
                if (exp_q.size() == 0) check("b_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("b_resp", 64'({1'b0, axi.bid, axi.bresp, 1'b0, 32'h0}), 64'(e));
                end
            end
            r_stall = axi.rvalid && !axi.rready;
            r_prev  = {axi.rid, axi.rresp, axi.rlast, axi.rdata};
            b_stall = axi.bvalid && !axi.bready;
            b_prev  = {axi.bid, axi.bresp};
        end
    end

    function automatic logic [31:0] mk_addr(input int word);
        return ($urandom() & 32'hFFFF_F000) | (32'(word) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // Called at posedge+1 with valid already raised; returns at posedge+1 after the handshake edge.
    task automatic wait_hs(input int ch, input string name);
        logic got;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            got = (ch == 0) ? axi.awready : (ch == 1) ? axi.wready : axi.arready;
            @(posedge clk);
            #1;
            if (got) return;
        end
        check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic write_burst(input logic [3:0] id, input int word, input int len, input logic [1:0] burst,
                               input logic [2:0] size, input int bad_beat, input bit gaps);
        bit err;
        bit last_drv;
        int idx;
        err = (burst != 2'b01) || (size != 3'd2);
        for (int n = 0; n <= len; n++) begin
            last_drv = (n == len) ^ (n == bad_beat);
            if (!err) begin
                idx = (word + n) % DEPTH;
                for (int k = 0; k < 4; k++)
                    if (wstrb_a[n][k]) model_mem[idx][8*k +: 8] = wdata_a[n][8*k +: 8];
            end
            if (last_drv != (n == len)) err = 1'b1;
        end
        exp_q.push_back({1'b0, id, err ? 2'b10 : 2'b00, 1'b0, 32'h0});
        @(posedge clk);
        #1;
        axi.awid = id; axi.awaddr = mk_addr(word); axi.awlen = 8'(len);
        axi.awburst = burst; axi.awsize = size; axi.awvalid = 1'b1;
        wait_hs(0, "aw_hs");
        axi.awvalid = 1'b0;
        for (int n = 0; n <= len; n++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            axi.wdata = wdata_a[n]; axi.wstrb = wstrb_a[n];
            axi.wlast = (n == len) ^ (n == bad_beat); axi.wvalid = 1'b1;
            wait_hs(1, "w_hs");
            axi.wvalid = 1'b0;
        end
        check("b_latency", 64'(axi.bvalid), 64'd1);
    endtask

    task automatic read_burst(input logic [3:0] id, input int word, input int len, input logic [1:0] burst,
                              input logic [2:0] size, input bit simul, input bit manual, output int cycles);
        bit err;
        @(posedge clk);
        #1;
        err = (burst != 2'b01) || (size != 3'd2);
        for (int n = 0; n <= len; n++)
            exp_q.push_back({1'b1, id, err ? 2'b10 : 2'b00, n == len, err ? 32'h0 : model_mem[(word + n) % DEPTH]});
        axi.arid = id; axi.araddr = mk_addr(word); axi.arlen = 8'(len);
        axi.arburst = burst; axi.arsize = size; axi.arvalid = 1'b1;
        if (simul) begin
            @(negedge clk);
            check("simul_awready", 64'(axi.awready), 64'd1);
            check("simul_arready", 64'(axi.arready), 64'd0);
            @(posedge clk);
            #1;
        end
        wait_hs(2, "ar_hs");
        axi.arvalid = 1'b0;
        if (simul) check("ar_after_b", 64'(exp_q.size()), 64'(len + 1));
        check("r_latency", 64'(axi.rvalid), 64'd1);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 3000) begin
            if (manual) axi.rready = pat[cycles % 4];
            @(posedge clk);
            #1;
            cycles++;
        end
        if (exp_q.size() != 0) begin
            check("r_drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        if (manual) axi.rready = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, rb0, op, word, len, sel, bad;
        logic [1:0] burst;
        logic [2:0] size;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'd2; axi.awburst = 2'b01;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd2; axi.arburst = 2'b01;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
        axi.rready = 1'b1; axi.bready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 64'({axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, axi.rlast}), 64'd0);
        check("rst_resp", 64'({axi.bresp, axi.rresp, axi.bid, axi.rid}), 64'd0);
        check("rst_rdata", 64'(axi.rdata), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_readies", 64'({axi.awready, axi.arready}), 64'b11);

        // Fill the whole RAM so every later read has a known expectation
        for (int b = 0; b < 4; b++) begin
            for (int n = 0; n < 256; n++) begin wdata_a[n] = $urandom(); wstrb_a[n] = 4'hF; end
            write_burst(4'(b), b * 256, 255, 2'b01, 3'd2, -1, 1'b0);
        end

        // Four-beat write/read at byte address 0x400
        for (int n = 0; n < 4; n++) begin wdata_a[n] = 32'h11 * (n + 1); wstrb_a[n] = 4'hF; end
        write_burst(4'h1, 256, 3, 2'b01, 3'd2, -1, 1'b0);
        read_burst(4'h2, 256, 3, 2'b01, 3'd2, 1'b0, 1'b0, cyc);

        // Full 256-beat burst with rready held high streams back to back
        for (int n = 0; n < 256; n++) begin wdata_a[n] = $urandom(); wstrb_a[n] = 4'hF; end
        write_burst(4'h3, 0, 255, 2'b01, 3'd2, -1, 1'b0);
        drain();
        rb0 = r_beats;
        read_burst(4'h4, 0, 255, 2'b01, 3'd2, 1'b0, 1'b0, cyc);
        check("r256_cycles", 64'(cyc), 64'd256);
        check("r256_beats", 64'(r_beats - rb0), 64'd256);

        // Byte strobes merge into the existing word
        wdata_a[0] = 32'hAABBCCDD; wstrb_a[0] = 4'hF;
        write_burst(4'h5, 5, 0, 2'b01, 3'd2, -1, 1'b0);
        wdata_a[0] = 32'h11223344; wstrb_a[0] = 4'b0101;
        write_burst(4'h6, 5, 0, 2'b01, 3'd2, -1, 1'b0);
        read_burst(4'h7, 5, 0, 2'b01, 3'd2, 1'b0, 1'b0, cyc);

        // rready pattern 1,0,0,1 during a four-beat read
        rr_manual = 1'b1;
        read_burst(4'h8, 256, 3, 2'b01, 3'd2, 1'b0, 1'b1, cyc);
        rr_manual = 1'b0;

        // Simultaneous AW and AR: write wins, read follows with the new data
        drain();
        repeat (2) @(posedge clk);
        for (int n = 0; n < 2; n++) begin wdata_a[n] = $urandom(); wstrb_a[n] = 4'hF; end
        fork
            write_burst(4'h9, 600, 1, 2'b01, 3'd2, -1, 1'b0);
            read_burst(4'hA, 600, 1, 2'b01, 3'd2, 1'b1, 1'b0, cyc);
        join

        // Wrap past the top of the RAM
        for (int n = 0; n < 4; n++) begin wdata_a[n] = $urandom(); wstrb_a[n] = 4'hF; end
        write_burst(4'hB, 1022, 3, 2'b01, 3'd2, -1, 1'b0);
        read_burst(4'hC, 1022, 3, 2'b01, 3'd2, 1'b0, 1'b0, cyc);
        read_burst(4'hD, 0, 1, 2'b01, 3'd2, 1'b0, 1'b0, cyc);

        // Error responses: FIXED/WRAP/size, early and missing wlast
        for (int n = 0; n < 4; n++) begin wdata_a[n] = $urandom(); wstrb_a[n] = 4'hF; end
        write_burst(4'h1, 500, 2, 2'b00, 3'd2, -1, 1'b0);
        read_burst(4'h2, 500, 2, 2'b01, 3'd2, 1'b0, 1'b0, cyc);
        read_burst(4'h3, 500, 2, 2'b10, 3'd2, 1'b0, 1'b0, cyc);
        read_burst(4'h4, 500, 1, 2'b01, 3'd1, 1'b0, 1'b0, cyc);
        write_burst(4'h5, 700, 3, 2'b01, 3'd2, 1, 1'b0);
        write_burst(4'h6, 710, 1, 2'b01, 3'd2, 1, 1'b0);
        read_burst(4'h7, 700, 3, 2'b01, 3'd2, 1'b0, 1'b0, cyc);
        read_burst(4'h8, 710, 1, 2'b01, 3'd2, 1'b0, 1'b0, cyc);

        // Randomized traffic with random back-pressure and W gaps
        rr_random = 1'b1;
        br_random = 1'b1;
        for (int t = 0; t < 60; t++) begin
            op   = $urandom_range(0, 1);
            word = $urandom_range(0, DEPTH - 1);
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            burst = 2'b01;
            size  = 3'd2;
            sel = $urandom_range(0, 9);
            if (sel == 0) burst = 2'b00;
            else if (sel == 1) burst = 2'b10;
            else if (sel == 2) size = 3'd1;
            if (op == 0) begin
                for (int n = 0; n <= len; n++) begin wdata_a[n] = $urandom(); wstrb_a[n] = 4'($urandom()); end
                bad = ($urandom_range(0, 11) == 0) ? $urandom_range(0, len) : -1;
                write_burst(4'($urandom()), word, len, burst, size, bad, 1'b1);
            end else begin
                read_burst(4'($urandom()), word, len, burst, size, 1'b0, 1'b0, cyc);
            end
        end
        drain();
        rr_random = 1'b0;
        br_random = 1'b0;

        // Reset in the middle of a read burst
        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < 16; n++) exp_q.push_back({1'b1, 4'hE, 2'b00, n == 15, model_mem[300 + n]});
        axi.arid = 4'hE; axi.araddr = mk_addr(300); axi.arlen = 8'd15;
        axi.arburst = 2'b01; axi.arsize = 3'd2; axi.arvalid = 1'b1;
        wait_hs(2, "ar_hs_rst");
        axi.arvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_rvalid", 64'({axi.rvalid, axi.rlast}), 64'd0);
        check("rst_mid_ready", 64'({axi.awready, axi.arready, axi.wready}), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        read_burst(4'h3, 256, 3, 2'b01, 3'd2, 1'b0, 1'b0, cyc);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
